scpu_pipe_fwd: RTL and testbench
================================

Name: scpu_pipe_fwd

Overview:
Parametrised 5-stage pipelined CPU, successor to the fixed 16x16-bit SCPU core. Register count, data width and address width are generic. Adds full operand forwarding and a load-use interlock, so dependent back-to-back instructions execute correctly. Sits between the instruction-stream driver and a single-port synchronous data RAM; exposes the whole register file for checking.

Parameters:
DW, 16, data and register width (bits)
NREG, 16, number of registers (power of 2, >=4); RW = log2(NREG)
AW, 13, data-memory address width (AW <= DW)
IW, 3+4*RW (derived, not overridable), instruction width; 19 at defaults

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction present on instruction
instruction  in  IW  [IW-1:IW-3]=op, then rs, rt, rd, rl fields (RW bits each, MSB first); imm = low 2*RW bits
MEM_out  in  DW  RAM read data, valid the cycle after ADDR/WEN=1 are sampled
busy  out  1  1 = instruction not accepted this cycle; driver holds it
out_valid  out  1  one retired instruction per pulse
reg_flat  out  NREG*DW  register i at [i*DW +: DW], registered
WEN  out  1  RAM write enable, active low
ADDR  out  AW  RAM address, registered
MEM_in  out  DW  RAM write data, registered

Behaviour:
- Reset (async, rst_n=0): all stage valids 0, all registers 0, out_valid=0, busy=0, WEN=1, ADDR=0, MEM_in=0. Reset mid-operation discards all in-flight instructions; no RAM write after reset asserts.
- Acceptance: instruction accepted at a rising edge with in_valid=1 and busy=0.
- Ops: op=000 R-type on func=rl field: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, writes rd; other func values are a NOP that still retires.
- 001 MULT: signed 2DW product; rd<=high DW bits, rl<=low DW bits.
- 010 BEQ: if rs==rt then rd<=1, rl<=0, else rd<=0, rl<=1. 111 SLT: same write pattern for signed rs<rt.
- 011 ADDI: rt<=rs+sext(imm). 100 SUBI: rt<=rs-sext(imm).
- 101 STORE: mem[(rs+sext(imm)) mod 2^AW] <= rt. 110 LOAD: rt <= that memory word.
- Arithmetic wraps modulo 2^DW. Dual-write ops with rd==rl: the rl write wins.
- Stages: S1 latches instruction; S2 decodes; S3 reads the register file combinationally, forwards operands, runs the ALU, and registers ADDR/WEN/MEM_in for LOAD/STORE (WEN=0 only for STORE, 1 otherwise); S4 is the RAM access cycle; S5 captures MEM_out for LOAD.
- Latency: writeback of an instruction accepted at edge E0 happens at E0+5. out_valid is 1 in the cycle after E0+5, and reg_flat already shows that result.
- Forwarding into S3 operands (rs, rt incl. STORE data), priority highest first: S4 result, S5 result (ALU or load data), register file. The dual-destination match checks rl before rd.
- Load-use interlock: if S3 sources a register that is a destination of a LOAD in S4, busy=1 (combinational) for one cycle. S1–S3 hold, and a bubble enters S4. Exactly one stall per such dependency; no other stalls.
- Bubbles and non-accepted cycles produce no out_valid and no RAM write.

Decomposition:
- Package scpu_pkg: opcode and func localparams, internal op enum (NOP, AND..LOAD), and a writes_rd/writes_rl/writes_rt helper function for destination decode.
- One sub-module, scpu_alu: combinational S3 datapath (logic/arith/mult/compare/address), parametrised by DW and AW.

Test Plan:
- Reset, then ADDI r1,r0,5 → out_valid 6 cycles after acceptance; reg_flat r1=5, others 0.
- ADDI r1,r0,3; ADD r2=r1+r1; SUB r3=r2-r1 issued back-to-back → r2=6, r3=3, busy never asserted.
- STORE r1→[r0+10] then LOAD r4←[r0+10]; ADD r5=r4+r4 issued next cycle → WEN=0, ADDR=10, MEM_in=3; busy=1 for exactly one cycle; r5=6.
- ADDI r1,r0,-1 (imm 0xFF); MULT rd=r6, rl=r7, r1*r1 → r6=0x0000, r7=0x0001.
- SLT r1=-1 < r0 → rd=1, rl=0; BEQ r0,r0 with rd==rl=r8 → r8=0 (rl write wins).
- rst_n low while a STORE is in S3 → no WEN=0 pulse, all outputs at reset values; NREG=8, DW=32 build passes the first three scenarios.

Source files
------------

// File: rtl/scpu_pkg.sv
// Shared definitions for the pipelined SCPU.
// Holds the 3-bit opcodes, the R-type func codes, the internal decoded op
// enum, and helpers that say which register fields an op reads or writes.
package scpu_pkg;

    localparam logic [2:0] OPC_RTYPE = 3'b000;
    localparam logic [2:0] OPC_MULT  = 3'b001;
    localparam logic [2:0] OPC_BEQ   = 3'b010;
    localparam logic [2:0] OPC_ADDI  = 3'b011;
    localparam logic [2:0] OPC_SUBI  = 3'b100;
    localparam logic [2:0] OPC_STORE = 3'b101;
    localparam logic [2:0] OPC_LOAD  = 3'b110;
    localparam logic [2:0] OPC_SLT   = 3'b111;

    localparam int unsigned FN_AND = 0;
    localparam int unsigned FN_OR  = 1;
    localparam int unsigned FN_XOR = 2;
    localparam int unsigned FN_ADD = 3;
    localparam int unsigned FN_SUB = 4;

    typedef enum logic [3:0] {
        OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB,
        OP_MULT, OP_BEQ, OP_SLT, OP_ADDI, OP_SUBI, OP_STORE, OP_LOAD
    } op_e;

    // Unknown R-type func codes collapse to NOP: they retire but touch nothing.
    function automatic op_e decode_op(input logic [2:0] opc, input int unsigned func);
        op_e op;
        op = OP_NOP;
        case (opc)
            OPC_RTYPE: begin
                case (func)
                    FN_AND:  op = OP_AND;
                    FN_OR:   op = OP_OR;
                    FN_XOR:  op = OP_XOR;
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    default: op = OP_NOP;
                endcase
            end
            OPC_MULT:  op = OP_MULT;
            OPC_BEQ:   op = OP_BEQ;
            OPC_ADDI:  op = OP_ADDI;
            OPC_SUBI:  op = OP_SUBI;
            OPC_STORE: op = OP_STORE;
            OPC_LOAD:  op = OP_LOAD;
            default:   op = OP_SLT;
        endcase
        return op;
    endfunction

    function automatic logic writes_rd(input op_e op);
        return (op inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB,
                           OP_MULT, OP_BEQ, OP_SLT});
    endfunction

    function automatic logic writes_rl(input op_e op);
        return (op inside {OP_MULT, OP_BEQ, OP_SLT});
    endfunction

    function automatic logic writes_rt(input op_e op);
        return (op inside {OP_ADDI, OP_SUBI, OP_LOAD});
    endfunction

    function automatic logic reads_rs(input op_e op);
        return (op != OP_NOP);
    endfunction

    function automatic logic reads_rt(input op_e op);
        return (op inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB,
                           OP_MULT, OP_BEQ, OP_SLT, OP_STORE});
    endfunction

endpackage

// File: rtl/scpu_alu.sv
// Combinational execute-stage datapath.
// Ports: op (decoded op), a (rs operand), b (rt operand), imm (sign-extended
// immediate); res_d = value for rd (or rt for ADDI/SUBI), res_l = value for rl,
// addr = LOAD/STORE address (rs + imm, truncated to AW bits).
module scpu_alu
    import scpu_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 13
) (
    input  op_e           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] res_d,
    output logic [DW-1:0] res_l,
    output logic [AW-1:0] addr
);

    logic signed [2*DW-1:0] prod;
    logic                   eq;
    logic                   lt;

    assign prod = $signed(a) * $signed(b);
    assign eq   = (a == b);
    assign lt   = ($signed(a) < $signed(b));
    assign addr = AW'(a + imm);

    always_comb begin
        res_d = '0;
        res_l = '0;
        case (op)
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_ADD:  res_d = a + b;
            OP_SUB:  res_d = a - b;
            OP_MULT: begin
                res_d = prod[2*DW-1:DW];
                res_l = prod[DW-1:0];
            end
            // Compare ops write a one-hot pair: rd=1/rl=0 when true.
            OP_BEQ: begin
                res_d = DW'(eq);
                res_l = DW'(!eq);
            end
            OP_SLT: begin
                res_d = DW'(lt);
                res_l = DW'(!lt);
            end
            OP_ADDI: res_d = a + imm;
            OP_SUBI: res_d = a - imm;
            default: begin
                res_d = '0;
                res_l = '0;
            end
        endcase
    end

endmodule

// File: rtl/scpu_pipe_fwd.sv
// Five-stage pipelined SCPU with full operand forwarding and a one-cycle
// load-use interlock.
// Ports: clk/rst_n; in_valid+instruction from the driver, busy back-pressure;
// out_valid pulses once per retired instruction; reg_flat exposes every
// register; WEN (active low)/ADDR/MEM_in drive a synchronous single-port RAM
// whose read data returns on MEM_out one cycle after ADDR is sampled.
// Stages: S1 latch, S2 decode, S3 read/forward/execute + RAM request,
// S4 RAM access, S5 load capture and writeback.
module scpu_pipe_fwd
    import scpu_pkg::*;
#(
    parameter  int DW   = 16,
    parameter  int NREG = 16,
    parameter  int AW   = 13,
    localparam int RW   = $clog2(NREG),
    localparam int IW   = 3 + 4 * RW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [IW-1:0]      instruction,
    input  logic [DW-1:0]      MEM_out,
    output logic               busy,
    output logic               out_valid,
    output logic [NREG*DW-1:0] reg_flat,
    output logic               WEN,
    output logic [AW-1:0]      ADDR,
    output logic [DW-1:0]      MEM_in
);

    genvar gi;

    // Pipeline state
    logic          s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic [IW-1:0] s1_instr_reg, s2_instr_reg;
    op_e           s3_op_reg;
    logic [RW-1:0] s3_rs_reg, s3_rt_reg, s3_rd_reg, s3_rl_reg;
    logic [DW-1:0] s3_imm_reg;

    // Each in-flight instruction carries up to two writes: "d" (rd or rt) and
    // "l" (rl). The l write is applied last so it wins when rd==rl.
    logic          s4_valid_reg, s4_load_reg, s4_we_d_reg, s4_we_l_reg;
    logic [RW-1:0] s4_wa_d_reg, s4_wa_l_reg;
    logic [DW-1:0] s4_wd_d_reg, s4_wd_l_reg;
    logic          s5_valid_reg, s5_load_reg, s5_we_d_reg, s5_we_l_reg;
    logic [RW-1:0] s5_wa_d_reg, s5_wa_l_reg;
    logic [DW-1:0] s5_wd_d_reg, s5_wd_l_reg;

    logic [DW-1:0] regs_reg [NREG];
    logic          out_valid_reg, wen_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] mem_in_reg;

    // Decode of the instruction sitting in S2
    logic [2:0]    s2_opc;
    logic [RW-1:0] s2_rs, s2_rt, s2_rd, s2_rl;
    logic [2*RW-1:0] s2_imm;
    op_e           dec_op;

    assign s2_opc = s2_instr_reg[IW-1 -: 3];
    assign s2_rs  = s2_instr_reg[4*RW-1 -: RW];
    assign s2_rt  = s2_instr_reg[3*RW-1 -: RW];
    assign s2_rd  = s2_instr_reg[2*RW-1 -: RW];
    assign s2_rl  = s2_instr_reg[RW-1:0];
    assign s2_imm = s2_instr_reg[2*RW-1:0];
    assign dec_op = decode_op(s2_opc, 32'(s2_rl));

    // Operand forwarding: S4 beats S5 beats the register file, and inside a
    // stage the rl write is checked first because it is the one that lands.
    logic [DW-1:0] opnd_rs, opnd_rt;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [RW-1:0] src;
            logic [DW-1:0] val;
            assign src = (gi == 0) ? s3_rs_reg : s3_rt_reg;
            always_comb begin
                if (s4_we_l_reg && (s4_wa_l_reg == src))
                    val = s4_wd_l_reg;
                else if (s4_we_d_reg && (s4_wa_d_reg == src))
                    val = s4_wd_d_reg;
                else if (s5_we_l_reg && (s5_wa_l_reg == src))
                    val = s5_wd_l_reg;
                else if (s5_we_d_reg && (s5_wa_d_reg == src))
                    val = s5_load_reg ? MEM_out : s5_wd_d_reg;
                else
                    val = regs_reg[src];
            end
        end
    endgenerate

    assign opnd_rs = g_fwd[0].val;
    assign opnd_rt = g_fwd[1].val;

    // A LOAD in S4 has no data yet; anything in S3 that needs it waits one
    // cycle and then picks the data up from S5 (MEM_out).
    logic stall, s3_go, accept;

    assign stall = s3_valid_reg && s4_load_reg &&
                   ((reads_rs(s3_op_reg) && (s3_rs_reg == s4_wa_d_reg)) ||
                    (reads_rt(s3_op_reg) && (s3_rt_reg == s4_wa_d_reg)));
    assign s3_go  = s3_valid_reg && !stall;
    assign accept = in_valid && !stall;

    logic [DW-1:0] alu_res_d, alu_res_l;
    logic [AW-1:0] alu_addr;

    scpu_alu #(
        .DW (DW),
        .AW (AW)
    ) u_alu (
        .op    (s3_op_reg),
        .a     (opnd_rs),
        .b     (opnd_rt),
        .imm   (s3_imm_reg),
        .res_d (alu_res_d),
        .res_l (alu_res_l),
        .addr  (alu_addr)
    );

    // Pipeline advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_instr_reg <= '0;
            s2_valid_reg <= 1'b0;
            s2_instr_reg <= '0;
            s3_valid_reg <= 1'b0;
            s3_op_reg    <= OP_NOP;
            s3_rs_reg    <= '0;
            s3_rt_reg    <= '0;
            s3_rd_reg    <= '0;
            s3_rl_reg    <= '0;
            s3_imm_reg   <= '0;
            s4_valid_reg <= 1'b0;
            s4_load_reg  <= 1'b0;
            s4_we_d_reg  <= 1'b0;
            s4_we_l_reg  <= 1'b0;
            s4_wa_d_reg  <= '0;
            s4_wa_l_reg  <= '0;
            s4_wd_d_reg  <= '0;
            s4_wd_l_reg  <= '0;
            s5_valid_reg <= 1'b0;
            s5_load_reg  <= 1'b0;
            s5_we_d_reg  <= 1'b0;
            s5_we_l_reg  <= 1'b0;
            s5_wa_d_reg  <= '0;
            s5_wa_l_reg  <= '0;
            s5_wd_d_reg  <= '0;
            s5_wd_l_reg  <= '0;
            wen_reg      <= 1'b1;
            addr_reg     <= '0;
            mem_in_reg   <= '0;
        end else begin
            if (!stall) begin
                s1_valid_reg <= accept;
                if (accept)
                    s1_instr_reg <= instruction;
                s2_valid_reg <= s1_valid_reg;
                s2_instr_reg <= s1_instr_reg;
                s3_valid_reg <= s2_valid_reg;
                s3_op_reg    <= dec_op;
                s3_rs_reg    <= s2_rs;
                s3_rt_reg    <= s2_rt;
                s3_rd_reg    <= s2_rd;
                s3_rl_reg    <= s2_rl;
                s3_imm_reg   <= {{(DW-2*RW){s2_imm[2*RW-1]}}, s2_imm};
            end

            // A stalled S3 sends a bubble into S4 (all write enables low).
            s4_valid_reg <= s3_go;
            s4_load_reg  <= s3_go && (s3_op_reg == OP_LOAD);
            s4_we_d_reg  <= s3_go && (writes_rd(s3_op_reg) || writes_rt(s3_op_reg));
            s4_we_l_reg  <= s3_go && writes_rl(s3_op_reg);
            s4_wa_d_reg  <= writes_rt(s3_op_reg) ? s3_rt_reg : s3_rd_reg;
            s4_wa_l_reg  <= s3_rl_reg;
            s4_wd_d_reg  <= alu_res_d;
            s4_wd_l_reg  <= alu_res_l;

            s5_valid_reg <= s4_valid_reg;
            s5_load_reg  <= s4_load_reg;
            s5_we_d_reg  <= s4_we_d_reg;
            s5_we_l_reg  <= s4_we_l_reg;
            s5_wa_d_reg  <= s4_wa_d_reg;
            s5_wa_l_reg  <= s4_wa_l_reg;
            s5_wd_d_reg  <= s4_wd_d_reg;
            s5_wd_l_reg  <= s4_wd_l_reg;

            wen_reg <= !(s3_go && (s3_op_reg == OP_STORE));
            if (s3_go && ((s3_op_reg == OP_STORE) || (s3_op_reg == OP_LOAD))) begin
                addr_reg   <= alu_addr;
                mem_in_reg <= opnd_rt;
            end
        end
    end

    // Writeback from S5; load data is taken straight off MEM_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs_reg[i] <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (s5_we_d_reg)
                regs_reg[s5_wa_d_reg] <= s5_load_reg ? MEM_out : s5_wd_d_reg;
            if (s5_we_l_reg)
                regs_reg[s5_wa_l_reg] <= s5_wd_l_reg;
            out_valid_reg <= s5_valid_reg;
        end
    end

    generate
        for (gi = 0; gi < NREG; gi++) begin : g_flat
            assign reg_flat[gi*DW +: DW] = regs_reg[gi];
        end
    endgenerate

    assign busy      = stall;
    assign out_valid = out_valid_reg;
    assign WEN       = wen_reg;
    assign ADDR      = addr_reg;
    assign MEM_in    = mem_in_reg;

endmodule

// File: tb/tb_scpu_pipe_fwd.sv
// Directed bench for scpu_pipe_fwd at default parameters, with a behavioural
// synchronous RAM attached to the memory port.
module tb_scpu_pipe_fwd;

    localparam int DW   = 16;
    localparam int NREG = 16;
    localparam int AW   = 13;
    localparam int RW   = 4;
    localparam int IW   = 3 + 4 * RW;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic [IW-1:0]      instruction = '0;
    logic [DW-1:0]      MEM_out;
    logic               busy;
    logic               out_valid;
    logic [NREG*DW-1:0] reg_flat;
    logic               WEN;
    logic [AW-1:0]      ADDR;
    logic [DW-1:0]      MEM_in;

    always #5 clk = ~clk;

    scpu_pipe_fwd #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .MEM_out     (MEM_out),
        .busy        (busy),
        .out_valid   (out_valid),
        .reg_flat    (reg_flat),
        .WEN         (WEN),
        .ADDR        (ADDR),
        .MEM_in      (MEM_in)
    );

    // Single-port synchronous RAM, read data one cycle after address.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (WEN == 1'b0)
            ram[ADDR] <= MEM_in;
        MEM_out <= ram[ADDR];
    end

    // Free-running event counters; scenarios look at deltas.
    int busy_cnt = 0;
    int ov_cnt   = 0;
    int wen_cnt  = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_din  = '0;

    always @(negedge clk) begin
        if (rst_n && busy)      busy_cnt <= busy_cnt + 1;
        if (rst_n && out_valid) ov_cnt   <= ov_cnt + 1;
        if (WEN == 1'b0) begin
            wen_cnt   <= wen_cnt + 1;
            last_addr <= ADDR;
            last_din  <= MEM_in;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_reg [NREG];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] get_reg(input int i);
        return reg_flat[i*DW +: DW];
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++)
            check_eq($sformatf("%s_r%0d", tag, i), {48'h0, get_reg(i)}, {48'h0, exp_reg[i]});
    endtask

    function automatic logic [IW-1:0] enc_r(input logic [2:0] op, input int rs, input int rt,
                                            input int rd, input int rl);
        return {op, 4'(rs), 4'(rt), 4'(rd), 4'(rl)};
    endfunction

    function automatic logic [IW-1:0] enc_i(input logic [2:0] op, input int rs, input int rt,
                                            input int imm);
        return {op, 4'(rs), 4'(rt), 8'(imm)};
    endfunction

    // Presents one instruction, waits (bounded) for busy to drop, and returns
    // just after the accepting rising edge.
    task automatic issue(input logic [IW-1:0] ins);
        int tries;
        tries = 0;
        @(negedge clk);
        in_valid    = 1'b1;
        instruction = ins;
        while (busy && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (busy)
            check_eq("accept_timeout", {63'h0, busy}, 64'h0);
        @(posedge clk);
        $display("[%0t] issued instruction 0x%05h", $time, ins);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid    = 1'b0;
        instruction = '0;
        repeat (n) @(negedge clk);
    endtask

    int first_ov;
    int b0, o0, w0;

    initial begin
        for (int i = 0; i < NREG; i++) exp_reg[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy",      {63'h0, busy}, 64'h0);
        check_eq("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check_eq("rst_wen",       {63'h0, WEN}, 64'h1);
        check_eq("rst_addr",      {51'h0, ADDR}, 64'h0);
        check_eq("rst_mem_in",    {48'h0, MEM_in}, 64'h0);
        check_eq("rst_regs_zero", {63'h0, |reg_flat}, 64'h0);
        rst_n = 1'b1;

        // 1: ADDI r1,r0,5 and its latency
        issue(enc_i(3'b011, 0, 1, 5));
        first_ov = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_valid    = 1'b0;
                instruction = '0;
            end
            if (out_valid && first_ov == 0) first_ov = k;
        end
        check_eq("s1_latency", 64'(first_ov), 64'd6);
        exp_reg[1] = 16'd5;
        check_regs("s1");

        // 2: back-to-back ALU chain through S4 forwarding
        b0 = busy_cnt; o0 = ov_cnt;
        issue(enc_i(3'b011, 0, 1, 3));
        issue(enc_r(3'b000, 1, 1, 2, 3));
        issue(enc_r(3'b000, 2, 1, 3, 4));
        idle(8);
        check_eq("s2_busy_cycles", 64'(busy_cnt - b0), 64'd0);
        check_eq("s2_retired", 64'(ov_cnt - o0), 64'd3);
        exp_reg[1] = 16'd3; exp_reg[2] = 16'd6; exp_reg[3] = 16'd3;
        check_regs("s2");

        // 3: STORE, LOAD, dependent ADD (load-use interlock)
        b0 = busy_cnt; w0 = wen_cnt;
        issue(enc_i(3'b101, 0, 1, 10));
        issue(enc_i(3'b110, 0, 4, 10));
        issue(enc_r(3'b000, 4, 4, 5, 3));
        idle(10);
        check_eq("s3_wen_pulses", 64'(wen_cnt - w0), 64'd1);
        check_eq("s3_addr", {51'h0, last_addr}, 64'd10);
        check_eq("s3_mem_in", {48'h0, last_din}, 64'd3);
        check_eq("s3_busy_cycles", 64'(busy_cnt - b0), 64'd1);
        exp_reg[4] = 16'd3; exp_reg[5] = 16'd6;
        check_regs("s3");

        // 4: ADDI r1,r0,-1 then MULT r6:r7 = r1*r1
        issue(enc_i(3'b011, 0, 1, -1));
        issue(enc_r(3'b001, 1, 1, 6, 7));
        idle(8);
        exp_reg[1] = 16'hFFFF; exp_reg[6] = 16'h0000; exp_reg[7] = 16'h0001;
        check_regs("s4");

        // 5: SLT, BEQ with rd==rl (both outcomes)
        issue(enc_r(3'b111, 1, 0, 9, 10));
        issue(enc_r(3'b010, 0, 0, 8, 8));
        issue(enc_r(3'b010, 0, 1, 11, 11));
        idle(8);
        exp_reg[9] = 16'd1; exp_reg[10] = 16'd0; exp_reg[8] = 16'd0; exp_reg[11] = 16'd1;
        check_regs("s5");

        // 6: XOR, S5 forwarding, AND, undefined func retires as NOP
        o0 = ov_cnt;
        issue(enc_r(3'b000, 1, 2, 12, 2));
        issue(enc_i(3'b011, 0, 13, 7));
        issue(enc_i(3'b011, 0, 14, 1));
        issue(enc_i(3'b100, 13, 15, 2));
        issue(enc_r(3'b000, 15, 13, 14, 0));
        issue(enc_r(3'b000, 1, 1, 3, 7));
        idle(8);
        check_eq("s6_retired", 64'(ov_cnt - o0), 64'd6);
        exp_reg[12] = 16'hFFF9; exp_reg[13] = 16'd7; exp_reg[14] = 16'd5; exp_reg[15] = 16'd5;
        check_regs("s6");

        // 7: reset while a STORE sits in S3
        w0 = wen_cnt; o0 = ov_cnt;
        issue(enc_i(3'b101, 0, 1, 20));
        @(negedge clk);
        in_valid    = 1'b0;
        instruction = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("s7_busy",      {63'h0, busy}, 64'h0);
        check_eq("s7_out_valid", {63'h0, out_valid}, 64'h0);
        check_eq("s7_wen",       {63'h0, WEN}, 64'h1);
        check_eq("s7_addr",      {51'h0, ADDR}, 64'h0);
        check_eq("s7_mem_in",    {48'h0, MEM_in}, 64'h0);
        check_eq("s7_regs_zero", {63'h0, |reg_flat}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("s7_no_write", 64'(wen_cnt - w0), 64'd0);
        check_eq("s7_no_retire", 64'(ov_cnt - o0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
